lsu_byte_sequencer: RTL and testbench
=====================================

// Module: lsu_byte_sequencer
// PURPOSE
//  Load/store initiator driving both ports of the 1024x8 dual-port data RAM
//  (async read, sync write). Turns one 32-bit byte/half/word load or store
//  request into one or two beats of little-endian byte-lane accesses.
//  Sits between the datapath's memory stage and the data RAM.
//  Returns sign- or zero-extended load data over a valid/ready response handshake.
// PARAMETERS
//  ADDR_W  10  RAM address width; request address bits above ADDR_W-1 are ignored (alias)
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  rst          in   1   synchronous reset, active-high
//  req_valid    in   1   request present
//  req_ready    out  1   high only in IDLE; accept = req_valid & req_ready
//  req_we       in   1   1 = store, 0 = load
//  req_size     in   2   00 byte, 01 half, 10 word (11 treated as word)
//  req_unsigned in   1   loads only: 1 = zero-extend, 0 = sign-extend
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, bytes taken from LSB up
//  rsp_valid    out  1   response held until rsp_ready
//  rsp_ready    in   1   response consumed when rsp_valid & rsp_ready
//  rsp_rdata    out  32  extended load data; 0 for stores
//  rsp_err      out  1   misaligned access (LSU_MISALIGN_TRAP_EN only, else tied 0)
//  addr_a/addr_b            out 10  RAM port addresses
//  data_in_a/data_in_b      out 8   RAM write data
//  we_a/we_b                out 1   RAM write enables
//  data_out_a/data_out_b    in  8   RAM async read data
// BEHAVIOUR
//  - Reset: state IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, addr/data_in=0; req_ready=1 from the first cycle after rst.
//  - we_a/we_b are forced 0 in any cycle rst is high, including a reset during a beat.
//  - FSM: IDLE -> BEAT0 on accept (req registered). BEAT0 -> BEAT1 if word, else RESP.
//    BEAT1 -> RESP. RESP -> IDLE on rsp_ready.
//  - Lane map: byte uses port A only (we_b=0). Half: A=addr, B=addr+1.
//    Word: BEAT0 A=addr, B=addr+1; BEAT1 A=addr+2, B=addr+3.
//  - Stores: data_in_a/b take the corresponding wdata byte; we high for exactly one cycle per beat.
//  - Loads: data_out_a/b are captured into byte lanes at the end of each beat.
//  - Ports A and B never write the same address in the same cycle.
//  - Latency: accept at cycle 0. rsp_valid at cycle 2 for byte/half, cycle 3 for word.
//  - rsp_rdata/rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
//  - Extension in RESP: byte -> bits[7] or zero; half -> bits[15] or zero.
//  - Aligned accesses never wrap: a word at 0x3FC uses 0x3FC..0x3FF.
//  - A new request is not accepted in the same cycle its predecessor's response retires.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//   - misaligned half (addr[0]) or word (addr[1:0]!=0) goes IDLE -> RESP with rsp_err=1
//     and no RAM write; rsp_valid at cycle 1.
//  LSU_MISALIGN_TRAP_EN undefined:
//   - misaligned low address bits are cleared (forced alignment); rsp_err is tied 0.
// STRUCTURE
//  - lsu_pkg: size_e {SZ_B,SZ_H,SZ_W}; state_e {IDLE,BEAT0,BEAT1,RESP}; RAM_DEPTH=1024.
//  - Sub-module load_extend: combinational size/unsigned extension of the 32-bit assembled lanes.
// TESTING
//  - Store word 0xDEADBEEF @0x010 -> RAM 0x10..0x13 = EF,BE,AD,DE; two write beats;
//    rsp_valid at cycle 3 with rsp_rdata 0.
//  - Load word @0x010 -> rsp_rdata 0xDEADBEEF. Load byte signed @0x013 -> 0xFFFFFFDE.
//    Load half unsigned @0x012 -> 0x0000DEAD.
//  - Store byte 0x5A @0x3FF -> only we_a pulses, addr_a=0x3FF; word load @0x3FC returns 0x5A in [31:24].
//  - Word @0x011 with trap: rsp_err=1 at cycle 1, RAM unchanged; without trap: access @0x010.
//  - Hold rsp_ready=0 for 3 cycles -> rsp_valid/rsp_rdata stable, req_ready=0, no RAM writes.
//  - Assert rst in BEAT1 of a word store -> bytes +2/+3 unchanged; IDLE and req_ready=1 next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store byte sequencer: access size, FSM states
// and the data RAM geometry.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam int RAM_DEPTH = 1024;

   // Size code 2'b11 is treated as a word access.
   function automatic size_e decode_size(input logic [1:0] code);
      case (code)
         2'b00:   return SZ_B;
         2'b01:   return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/lsu_byte_sequencer_load_extend.sv
// load_extend: turns the assembled little-endian byte lanes of a load into
// the 32-bit response word, sign- or zero-extending byte and half accesses.
module load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] lanes,
   input  size_e       size,
   input  logic        is_unsigned,
   output logic [31:0] rdata
);

   function automatic logic [31:0] extend(input logic [31:0] l,
                                          input size_e       sz,
                                          input logic        zext);
      logic signed [7:0]  sb;
      logic signed [15:0] sh;
      logic signed [31:0] r;
      sb = l[7:0];
      sh = l[15:0];
      case (sz)
         SZ_B: begin
            if (zext) r = {24'd0, l[7:0]};
            else      r = 32'(sb);
         end
         SZ_H: begin
            if (zext) r = {16'd0, l[15:0]};
            else      r = 32'(sh);
         end
         default: r = l;
      endcase
      return r;
   endfunction

   // Purely combinational extension of the captured lanes.
   always_comb begin
      rdata = extend(lanes, size, is_unsigned);
   end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// lsu_byte_sequencer: drives both ports of a 1024x8 dual-port data RAM
// (async read, sync write) to perform one byte/half/word load or store per
// request, in one or two beats of two byte lanes each, and returns extended
// load data over a valid/ready response handshake.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses with rsp_err instead of silently aligning them down.
module lsu_byte_sequencer
   import lsu_pkg::*;
#(
   parameter int ADDR_W = $clog2(RAM_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] addr_a,
   output logic [ADDR_W-1:0] addr_b,
   output logic [7:0]        data_in_a,
   output logic [7:0]        data_in_b,
   output logic              we_a,
   output logic              we_b,
   input  logic [7:0]        data_out_a,
   input  logic [7:0]        data_out_b
);

   state_e              state, state_nxt;
   logic                accept;
   size_e               size_in;
   logic [ADDR_W-1:0]   addr_in;
   logic                trap_in;

   // Request captured at accept.
   logic                we_p0;
   logic                uns_p0;
   size_e               size_p0;
   logic [ADDR_W-1:0]   addr_p0;
   logic [31:0]         wdata_p0;
   logic                err_p0;

   // Load bytes captured at the end of each beat.
   logic [31:0]         lanes_p1;
   logic [31:0]         ext_rdata;

   // Address bits above the RAM range alias onto it.
   logic                unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_W];

   function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a,
                                               input size_e             sz);
      case (sz)
         SZ_B:    return a;
         SZ_H:    return {a[ADDR_W-1:1], 1'b0};
         default: return {a[ADDR_W-1:2], 2'b00};
      endcase
   endfunction

   assign size_in = decode_size(req_size);
   assign addr_in = req_addr[ADDR_W-1:0];
   assign accept  = req_valid && (state == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap_in = ((size_in == SZ_H) && addr_in[0]) ||
                    ((size_in == SZ_W) && (addr_in[1:0] != 2'b00));
`else
   assign trap_in = 1'b0;
`endif

   // State register and trap flag; the only reset state in the block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         err_p0 <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) err_p0 <= trap_in;
      end
   end

   // Request capture; address is stored already aligned to the access size.
   always_ff @(posedge clk) begin
      if (accept) begin
         we_p0    <= req_we;
         uns_p0   <= req_unsigned;
         size_p0  <= size_in;
         addr_p0  <= align(addr_in, size_in);
         wdata_p0 <= req_wdata;
      end
   end

   // Load lane capture: BEAT0 fills bytes 0/1 (clearing the upper half), BEAT1 bytes 2/3.
   always_ff @(posedge clk) begin
      if (state == BEAT0) begin
         lanes_p1[7:0]   <= data_out_a;
         lanes_p1[15:8]  <= (size_p0 == SZ_B) ? 8'd0 : data_out_b;
         lanes_p1[31:16] <= 16'd0;
      end else if (state == BEAT1) begin
         lanes_p1[23:16] <= data_out_a;
         lanes_p1[31:24] <= data_out_b;
      end
   end

   // Next-state and RAM/handshake outputs; write enables are killed while rst is high.
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      addr_a    = '0;
      addr_b    = '0;
      data_in_a = 8'd0;
      data_in_b = 8'd0;
      we_a      = 1'b0;
      we_b      = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (accept) state_nxt = trap_in ? RESP : BEAT0;
         end
         BEAT0: begin
            addr_a = addr_p0;
            if (we_p0) begin
               data_in_a = wdata_p0[7:0];
               we_a      = !rst;
            end
            if (size_p0 != SZ_B) begin
               addr_b = addr_p0 + ADDR_W'(1);
               if (we_p0) begin
                  data_in_b = wdata_p0[15:8];
                  we_b      = !rst;
               end
            end
            state_nxt = (size_p0 == SZ_W) ? BEAT1 : RESP;
         end
         BEAT1: begin
            addr_a = addr_p0 + ADDR_W'(2);
            addr_b = addr_p0 + ADDR_W'(3);
            if (we_p0) begin
               data_in_a = wdata_p0[23:16];
               data_in_b = wdata_p0[31:24];
               we_a      = !rst;
               we_b      = !rst;
            end
            state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   load_extend u_load_extend (
      .lanes       (lanes_p1),
      .size        (size_p0),
      .is_unsigned (uns_p0),
      .rdata       (ext_rdata)
   );

   // Response data is zero for stores and trapped accesses, and outside RESP.
   assign rsp_rdata = ((state == RESP) && !we_p0 && !err_p0) ? ext_rdata : 32'd0;

`ifdef LSU_MISALIGN_TRAP_EN
   assign rsp_err = (state == RESP) && err_p0;
`else
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Bench for lsu_byte_sequencer: a behavioural RAM, a transaction-level
// reference model of memory contents and responses, directed cases and a
// randomized request stream.
module tb_lsu_byte_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic [9:0]  addr_a, addr_b;
   logic [7:0]  data_in_a, data_in_b, data_out_a, data_out_b;
   logic        we_a, we_b;

   always #5 clk = ~clk;

   lsu_byte_sequencer dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .addr_a(addr_a), .addr_b(addr_b), .data_in_a(data_in_a), .data_in_b(data_in_b),
      .we_a(we_a), .we_b(we_b), .data_out_a(data_out_a), .data_out_b(data_out_b)
   );

   // Behavioural data RAM: async read, sync write.
   logic [7:0] mem     [0:1023];
   logic [7:0] ref_mem [0:1023];
   logic       load_init;

   assign data_out_a = mem[addr_a];
   assign data_out_b = mem[addr_b];

   always @(posedge clk) begin
      if (load_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
      end else begin
         if (we_a) mem[addr_a] <= data_in_a;
         if (we_b) mem[addr_b] <= data_in_b;
      end
   end

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference of the transaction in flight.
   logic        cur_act = 1'b0;
   logic        cur_we  = 1'b0;
   int          cur_base = 0;
   int          cur_n    = 1;
   logic [31:0] cur_wdata = 32'd0;
   logic [31:0] exp_rdata = 32'd0;
   logic        exp_err   = 1'b0;
   int          wcnt      = 0;

   // Per-cycle compare of DUT outputs against the in-flight reference.
   always @(negedge clk) begin
      int  off;
      logic ok;
      if (rst) begin
         chk("we_during_rst", {30'd0, we_a, we_b}, 32'd0);
      end else begin
         if (rsp_valid) begin
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
            chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
            chk("write_in_resp", {31'd0, we_a | we_b}, 32'd0);
         end
         if (we_a) begin
            wcnt++;
            off = int'(addr_a) - cur_base;
            ok  = cur_act && cur_we && !exp_err && off >= 0 && off < cur_n && (off % 2 == 0);
            chk("we_a_lane", {31'd0, ok}, 32'd1);
            if (ok) chk("data_in_a", {24'd0, data_in_a}, (cur_wdata >> (8 * off)) & 32'hFF);
         end
         if (we_b) begin
            wcnt++;
            off = int'(addr_b) - cur_base;
            ok  = cur_act && cur_we && !exp_err && cur_n > 1 && off >= 0 && off < cur_n && (off % 2 == 1);
            chk("we_b_lane", {31'd0, ok}, 32'd1);
            if (ok) chk("data_in_b", {24'd0, data_in_b}, (cur_wdata >> (8 * off)) & 32'hFF);
         end
         if (we_a && we_b) chk("same_addr_write", {31'd0, addr_a == addr_b}, 32'd0);
      end
   end

   // One complete request/response transaction, checked against the model.
   task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int hold, output logic [31:0] rd);
      int   n, a, base, lat, k;
      logic err;
      logic [31:0] v;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      a = int'(addr[9:0]);
`ifdef LSU_MISALIGN_TRAP_EN
      err = (a % n) != 0;
`else
      err = 1'b0;
`endif
      base = a - (a % n);
      lat  = err ? 1 : (n == 4) ? 3 : 2;
      v = 32'd0;
      if (!we && !err) begin
         for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
         if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      end
      rd = 32'd0;
      @(negedge clk);
      exp_rdata = v; exp_err = err;
      cur_we = we; cur_base = base; cur_n = n; cur_wdata = wd; cur_act = 1'b1;
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      k = 0;
      while (!req_ready && k < 20) begin @(negedge clk); k++; end
      if (!req_ready) begin
         chk("accept_wait", k, 0);
         req_valid = 1'b0; cur_act = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      wcnt = 0;
      if (we && !err)
         for (int i = 0; i < n; i++) ref_mem[base + i] = 8'((wd >> (8 * i)) & 32'hFF);
      k = 1;
      while (!rsp_valid && k < 20) begin @(posedge clk); #1; k++; end
      chk("rsp_latency", k, lat);
      repeat (hold) begin @(posedge clk); #1; end
      rd = rsp_rdata;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("rsp_retired", {31'd0, rsp_valid}, 32'd0);
      chk("req_ready_after_rsp", {31'd0, req_ready}, 32'd1);
      chk("write_count", wcnt, (we && !err) ? n : 0);
      cur_act = 1'b0;
   endtask

   logic [31:0] rd;
   logic [7:0]  orig2, orig3;

   initial begin
      rst = 1'b1; load_init = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; load_init = 1'b0;

      chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
      chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("reset_addr", {12'd0, addr_a, addr_b}, 32'd0);
      chk("reset_data_in", {16'd0, data_in_a, data_in_b}, 32'd0);

      // Directed cases with literal expectations.
      do_req(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 0, rd);
      chk("store_word_rdata", rd, 32'd0);
      chk("store_word_ram", {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]}, 32'hDEADBEEF);
      do_req(1'b0, 2'd2, 1'b0, 32'h010, 32'd0, 0, rd);
      chk("load_word", rd, 32'hDEADBEEF);
      do_req(1'b0, 2'd0, 1'b0, 32'h013, 32'd0, 0, rd);
      chk("load_byte_signed", rd, 32'hFFFFFFDE);
      do_req(1'b0, 2'd1, 1'b1, 32'h012, 32'd0, 1, rd);
      chk("load_half_unsigned", rd, 32'h0000DEAD);
      do_req(1'b0, 2'd1, 1'b0, 32'h012, 32'd0, 0, rd);
      chk("load_half_signed", rd, 32'hFFFFDEAD);
      do_req(1'b0, 2'd0, 1'b1, 32'h010, 32'd0, 0, rd);
      chk("load_byte_unsigned", rd, 32'h000000EF);
      do_req(1'b0, 2'd3, 1'b0, 32'hABCD_0010, 32'd0, 0, rd);
      chk("load_alias_size3", rd, 32'hDEADBEEF);

      do_req(1'b1, 2'd0, 1'b0, 32'h3FF, 32'h1234565A, 0, rd);
      chk("store_byte_top", {24'd0, mem[10'h3FF]}, 32'h5A);
      do_req(1'b0, 2'd2, 1'b1, 32'h3FC, 32'd0, 0, rd);
      chk("load_word_top_msb", {24'd0, rd[31:24]}, 32'h5A);

      do_req(1'b1, 2'd2, 1'b0, 32'h011, 32'h11223344, 0, rd);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("misaligned_ram_kept", {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]}, 32'hDEADBEEF);
`else
      chk("misaligned_ram_aligned", {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]}, 32'h11223344);
`endif

      do_req(1'b0, 2'd2, 1'b0, 32'h010, 32'd0, 3, rd);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("held_load", rd, 32'hDEADBEEF);
`else
      chk("held_load", rd, 32'h11223344);
`endif

      // Reset during BEAT1 of a word store.
      orig2 = ref_mem[10'h202]; orig3 = ref_mem[10'h203];
      @(negedge clk);
      exp_rdata = 32'd0; exp_err = 1'b0;
      cur_we = 1'b1; cur_base = 32'h200; cur_n = 4; cur_wdata = 32'h55667788; cur_act = 1'b1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h200; req_wdata = 32'h55667788;
      chk("rstbeat_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstbeat_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rstbeat_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      cur_act = 1'b0;
      ref_mem[10'h200] = 8'h88; ref_mem[10'h201] = 8'h77;
      @(negedge clk);
      chk("rstbeat_low_bytes", {16'd0, mem[10'h201], mem[10'h200]}, 32'h7788);
      chk("rstbeat_byte2", {24'd0, mem[10'h202]}, {24'd0, orig2});
      chk("rstbeat_byte3", {24'd0, mem[10'h203]}, {24'd0, orig3});

      // Randomized stream against the reference model.
      for (int t = 0; t < 200; t++) begin
         do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom_range(0, 2), rd);
      end

      @(negedge clk);
      for (int i = 0; i < 1024; i++)
         chk($sformatf("ram_final[%0h]", i), {24'd0, mem[i]}, {24'd0, ref_mem[i]});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
